branch_resolve: RTL and testbench
=================================

// Module: branch_resolve
// PURPOSE
//  Stage directly downstream of the ALU comparator in the NPC execute path. Consumes the
//  64-bit compare result (bit 0 significant) plus branch op, PC, imm and src1. Decides
//  taken/not-taken and the target, and drives the fetch redirect. It also drops wrong-path
//  instructions until fetch accepts the redirect, and buffers each resolved instruction in
//  a one-entry valid/ready output register toward write-back.
// PARAMETERS
//  XLEN   64  datapath width (pc, imm, src1, targets)
//  CNT_W  32  width of performance counters
// PORTS
//  clk             in   1      clock, rising edge
//  rst             in   1      async reset, active-high
//  in_valid        in   1      upstream entry valid
//  in_ready        out  1      block can take an entry this cycle
//  in_pc           in   XLEN   PC of instruction
//  in_imm          in   XLEN   sign-extended immediate
//  in_src1         in   XLEN   rs1 value (JALR base)
//  in_br_op        in   3      0 NONE,1 COND,2 COND_INV,3 JAL,4 JALR, 5-7 = NONE
//  in_cmp_result   in   XLEN   comparator output; only bit 0 used
//  out_valid       out  1      output register holds an entry
//  out_ready       in   1      downstream accepts entry
//  out_pc/out_link out  XLEN   pc, pc+4 (link value for rd)
//  out_taken       out  1      control transfer taken
//  out_target      out  XLEN   computed target (valid when out_taken or out_exc)
//  out_exc         out  1      instruction-address-misaligned
//  redirect_valid  out  1      fetch must restart at redirect_pc
//  redirect_ready  in   1      fetch accepts redirect
//  redirect_pc     out  XLEN   new fetch PC
//  cnt_branch/cnt_taken/cnt_squash out CNT_W  resolved ops / taken / squashed entries
// BEHAVIOUR
//  Reset: all outputs 0, state RUN, counters 0. Async assert; sync use from next edge.
//  taken: COND=cmp[0]; COND_INV=~cmp[0] (BGEU); JAL/JALR=1; NONE=0.
//  target: COND/COND_INV/JAL = pc+imm; JALR = (src1+imm) & ~1. Mod 2^XLEN, wraps.
//  link = pc+4 mod 2^XLEN, for every op.
//  exc = taken && target[1:0]!=0 (no RVC). exc entries report taken=0 and issue no redirect.
//  States: RUN, REDIR.
//   RUN: in_ready = ~out_valid | out_ready. On in_valid&in_ready, latch entry next edge
//     (latency 1). If taken&~exc: redirect_valid<=1, redirect_pc<=target, go REDIR.
//   REDIR: in_ready=1; every accepted input is discarded (no out entry), cnt_squash+1.
//     Hold redirect_valid/redirect_pc stable until redirect_valid&redirect_ready. On that
//     edge go RUN and clear redirect_valid. An input accepted in the same cycle is still
//     discarded.
//  Output reg: out_valid set on latch, cleared on out_valid&out_ready w/o new latch.
//   Accept+drain in the same cycle is allowed, so back-to-back throughput is 1/cycle.
//   Fields are held stable while out_valid&~out_ready.
//   The taken entry is latched in the same edge that enters REDIR, so it is never lost.
//  Counters: cnt_branch +1 per latched op!=NONE; cnt_taken +1 per taken&~exc.
//   All counters wrap at 2^CNT_W with no saturation.
//  rst mid-operation: pending redirect and out entry are dropped; state RUN.
// TESTING
//  T1 COND, cmp=1, pc=0x8000_0000, imm=0x10 -> next cycle out_taken=1,
//     target=redirect_pc=0x8000_0010, link=0x8000_0004, state REDIR.
//  T2 COND_INV, cmp=1 -> taken=0, no redirect. Same with cmp=0 -> target pc+imm taken.
//  T3 JALR src1=0x8000_0103, imm=0 -> target 0x8000_0102, exc=1, redirect_valid stays 0.
//  T4 taken branch; hold redirect_ready=0 for 3 cycles while feeding 3 inputs ->
//     cnt_squash=3, no out entries, redirect_pc stable. redirect_ready=1 -> RUN next cycle.
//  T5 out_ready=0 with out_valid=1 -> in_ready=0, fields stable. 10 back-to-back NONE ops
//     with out_ready=1 -> 10 outputs in 10 cycles.
//  T6 JAL pc=0xFFFF_FFFF_FFFF_FFF0, imm=0x20 -> target 0x10 (wrap). Preset cnt_taken to
//     2^32-1, one more taken -> 0. Assert rst in REDIR -> all outputs 0 immediately.

Source files
------------

// File: rtl/branch_resolve_if.sv
// Handshake bundle between execute, fetch redirect and write-back for branch_resolve.
// The slave modport is the resolve stage itself; master is the surrounding pipeline.
interface branch_resolve_if #(
    parameter int unsigned XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;
    logic [XLEN-1:0] in_src1;
    logic [2:0]      in_br_op;
    logic [XLEN-1:0] in_cmp_result;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_link;
    logic            out_taken;
    logic [XLEN-1:0] out_target;
    logic            out_exc;

    logic            redirect_valid;
    logic            redirect_ready;
    logic [XLEN-1:0] redirect_pc;

    modport slave (
        input  in_valid, in_pc, in_imm, in_src1, in_br_op, in_cmp_result,
        output in_ready,
        output out_valid, out_pc, out_link, out_taken, out_target, out_exc,
        input  out_ready,
        output redirect_valid, redirect_pc,
        input  redirect_ready
    );

    modport master (
        output in_valid, in_pc, in_imm, in_src1, in_br_op, in_cmp_result,
        input  in_ready,
        input  out_valid, out_pc, out_link, out_taken, out_target, out_exc,
        output out_ready,
        input  redirect_valid, redirect_pc,
        output redirect_ready
    );
endinterface

// File: rtl/branch_resolve.sv
// Branch resolution stage: decides taken/target, raises the fetch redirect, squashes
// wrong-path entries until fetch accepts it, and holds one resolved entry for write-back.
module branch_resolve #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    branch_resolve_if.slave  bus,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_taken,
    output logic [CNT_W-1:0] cnt_squash
);
    typedef enum logic [0:0] {StRun, StRedir} state_e;

    localparam logic [2:0]       OpCond    = 3'd1;
    localparam logic [2:0]       OpCondInv = 3'd2;
    localparam logic [2:0]       OpJal     = 3'd3;
    localparam logic [2:0]       OpJalr    = 3'd4;
    localparam logic [XLEN-1:0]  LinkOff   = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [XLEN-1:0]  ClrBit0   = {{(XLEN-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] CntOne    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_pc_q, out_pc_d;
    logic [XLEN-1:0]   out_link_q, out_link_d;
    logic              out_taken_q, out_taken_d;
    logic [XLEN-1:0]   out_target_q, out_target_d;
    logic              out_exc_q, out_exc_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]  cnt_branch_q, cnt_branch_d;
    logic [CNT_W-1:0]  cnt_taken_q, cnt_taken_d;
    logic [CNT_W-1:0]  cnt_squash_q, cnt_squash_d;

    logic              is_branch, taken_raw, exc, taken, accept;
    logic [XLEN-1:0]   target;

    // Only bit 0 of the comparator result carries information.
    logic unused_cmp;
    assign unused_cmp = ^bus.in_cmp_result[XLEN-1:1];

    // Decode the incoming op into taken / target / misalignment.
    always_comb begin
        is_branch = 1'b0;
        taken_raw = 1'b0;
        target    = bus.in_pc + bus.in_imm;
        case (bus.in_br_op)
            OpCond: begin
                is_branch = 1'b1;
                taken_raw = bus.in_cmp_result[0];
            end
            OpCondInv: begin
                is_branch = 1'b1;
                taken_raw = ~bus.in_cmp_result[0];
            end
            OpJal: begin
                is_branch = 1'b1;
                taken_raw = 1'b1;
            end
            OpJalr: begin
                is_branch = 1'b1;
                taken_raw = 1'b1;
                target    = (bus.in_src1 + bus.in_imm) & ClrBit0;
            end
            default: ;
        endcase
        exc   = taken_raw & (target[1:0] != 2'b00);
        taken = taken_raw & ~exc;
    end

    // While squashing we always sink input; otherwise accept when the output slot frees.
    assign bus.in_ready = ~rst & ((state_q == StRedir) | ~out_valid_q | bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;

    // Next-state: FSM, output register, redirect and counters.
    always_comb begin
        state_d          = state_q;
        out_valid_d      = out_valid_q;
        out_pc_d         = out_pc_q;
        out_link_d       = out_link_q;
        out_taken_d      = out_taken_q;
        out_target_d     = out_target_q;
        out_exc_d        = out_exc_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        cnt_branch_d     = cnt_branch_q;
        cnt_taken_d      = cnt_taken_q;
        cnt_squash_d     = cnt_squash_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            StRun: begin
                if (accept) begin
                    out_valid_d  = 1'b1;
                    out_pc_d     = bus.in_pc;
                    out_link_d   = bus.in_pc + LinkOff;
                    out_taken_d  = taken;
                    out_target_d = target;
                    out_exc_d    = exc;
                    if (is_branch) begin
                        cnt_branch_d = cnt_branch_q + CntOne;
                    end
                    if (taken) begin
                        cnt_taken_d      = cnt_taken_q + CntOne;
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = target;
                        state_d          = StRedir;
                    end
                end
            end
            StRedir: begin
                // Wrong-path entries are dropped, even in the handshake cycle.
                if (accept) begin
                    cnt_squash_d = cnt_squash_q + CntOne;
                end
                if (redirect_valid_q && bus.redirect_ready) begin
                    redirect_valid_d = 1'b0;
                    state_d          = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StRun;
            out_valid_q      <= 1'b0;
            out_pc_q         <= '0;
            out_link_q       <= '0;
            out_taken_q      <= 1'b0;
            out_target_q     <= '0;
            out_exc_q        <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            cnt_branch_q     <= '0;
            cnt_taken_q      <= '0;
            cnt_squash_q     <= '0;
        end else begin
            state_q          <= state_d;
            out_valid_q      <= out_valid_d;
            out_pc_q         <= out_pc_d;
            out_link_q       <= out_link_d;
            out_taken_q      <= out_taken_d;
            out_target_q     <= out_target_d;
            out_exc_q        <= out_exc_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            cnt_branch_q     <= cnt_branch_d;
            cnt_taken_q      <= cnt_taken_d;
            cnt_squash_q     <= cnt_squash_d;
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.out_pc         = out_pc_q;
    assign bus.out_link       = out_link_q;
    assign bus.out_taken      = out_taken_q;
    assign bus.out_target     = out_target_q;
    assign bus.out_exc        = out_exc_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign cnt_branch         = cnt_branch_q;
    assign cnt_taken          = cnt_taken_q;
    assign cnt_squash         = cnt_squash_q;
endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve. A second instance with 3-bit counters sees the
// same stimulus so counter wrap-around is exercised in a short run.
module tb_branch_resolve;
    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] link;
        logic [63:0] target;
        logic        taken;
        logic        exc;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_resolve_if #(.XLEN(64)) bus ();
    branch_resolve_if #(.XLEN(64)) bus2 ();

    logic [31:0] cnt_branch, cnt_taken, cnt_squash;
    logic [2:0]  cnt2_branch, cnt2_taken, cnt2_squash;

    branch_resolve #(.XLEN(64), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .cnt_branch (cnt_branch),
        .cnt_taken  (cnt_taken),
        .cnt_squash (cnt_squash)
    );

    branch_resolve #(.XLEN(64), .CNT_W(3)) dut_small (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus2),
        .cnt_branch (cnt2_branch),
        .cnt_taken  (cnt2_taken),
        .cnt_squash (cnt2_squash)
    );

    assign bus2.in_valid       = bus.in_valid;
    assign bus2.in_pc          = bus.in_pc;
    assign bus2.in_imm         = bus.in_imm;
    assign bus2.in_src1        = bus.in_src1;
    assign bus2.in_br_op       = bus.in_br_op;
    assign bus2.in_cmp_result  = bus.in_cmp_result;
    assign bus2.out_ready      = bus.out_ready;
    assign bus2.redirect_ready = bus.redirect_ready;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_out   = 0;
    entry_t      sb[$];
    logic        m_redir, m_out_valid;
    logic [63:0] m_redir_pc;
    logic [31:0] m_cnt_branch, m_cnt_taken, m_cnt_squash;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic entry_t model(input logic [2:0] op, input logic [63:0] pc,
                                     input logic [63:0] imm, input logic [63:0] src1,
                                     input logic c);
        entry_t e;
        logic   tk;
        tk       = (op == 3'd1) ? c : (op == 3'd2) ? ~c : (op == 3'd3 || op == 3'd4);
        e.pc     = pc;
        e.link   = pc + 64'd4;
        e.target = (op == 3'd4) ? ((src1 + imm) & ~64'd1) : (pc + imm);
        e.exc    = tk && (e.target[1:0] != 2'b00);
        e.taken  = tk && !e.exc;
        return e;
    endfunction

    task automatic model_reset();
        sb.delete();
        m_redir      = 1'b0;
        m_out_valid  = 1'b0;
        m_redir_pc   = '0;
        m_cnt_branch = '0;
        m_cnt_taken  = '0;
        m_cnt_squash = '0;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [63:0] pc,
                         input logic [63:0] imm, input logic [63:0] src1, input logic c);
        bus.in_valid      = v;
        bus.in_br_op      = op;
        bus.in_pc         = pc;
        bus.in_imm        = imm;
        bus.in_src1       = src1;
        bus.in_cmp_result = {63'h5a5a, c};
    endtask

    // Called at a falling edge with inputs set; checks, advances one clock, returns at the
    // next falling edge.
    task automatic cycle();
        logic   rdy, acc, drain, hs, nv, nredir;
        entry_t e;
        #1;
        rdy = m_redir | ~m_out_valid | bus.out_ready;
        check_eq("in_ready", 64'(bus.in_ready), 64'(rdy));
        check_eq("out_valid", 64'(bus.out_valid), 64'(m_out_valid));
        check_eq("out_valid_small", 64'(bus2.out_valid), 64'(m_out_valid));
        check_eq("redirect_valid", 64'(bus.redirect_valid), 64'(m_redir));
        if (m_redir) check_eq("redirect_pc", bus.redirect_pc, m_redir_pc);
        check_eq("cnt_branch", 64'(cnt_branch), 64'(m_cnt_branch));
        check_eq("cnt_taken", 64'(cnt_taken), 64'(m_cnt_taken));
        check_eq("cnt_squash", 64'(cnt_squash), 64'(m_cnt_squash));
        check_eq("cnt_branch_wrap", 64'(cnt2_branch), 64'(m_cnt_branch[2:0]));
        check_eq("cnt_taken_wrap", 64'(cnt2_taken), 64'(m_cnt_taken[2:0]));
        check_eq("cnt_squash_wrap", 64'(cnt2_squash), 64'(m_cnt_squash[2:0]));
        if (m_out_valid) begin
            check_eq("sb_empty", 64'(sb.size() == 0), 64'd0);
            if (sb.size() != 0) begin
                e = sb[0];
                check_eq("out_pc", bus.out_pc, e.pc);
                check_eq("out_link", bus.out_link, e.link);
                check_eq("out_taken", 64'(bus.out_taken), 64'(e.taken));
                check_eq("out_exc", 64'(bus.out_exc), 64'(e.exc));
                if (e.taken || e.exc) check_eq("out_target", bus.out_target, e.target);
            end
        end
        drain  = m_out_valid & bus.out_ready;
        acc    = bus.in_valid & rdy;
        hs     = m_redir & bus.redirect_ready;
        nv     = m_out_valid;
        nredir = m_redir;
        if (drain) begin
            n_out++;
            if (sb.size() != 0) e = sb.pop_front();
            nv = 1'b0;
        end
        if (acc && m_redir) begin
            m_cnt_squash++;
        end else if (acc) begin
            e = model(bus.in_br_op, bus.in_pc, bus.in_imm, bus.in_src1, bus.in_cmp_result[0]);
            sb.push_back(e);
            nv = 1'b1;
            if (bus.in_br_op >= 3'd1 && bus.in_br_op <= 3'd4) m_cnt_branch++;
            if (e.taken) begin
                m_cnt_taken++;
                nredir     = 1'b1;
                m_redir_pc = e.target;
            end
        end
        if (hs) nredir = 1'b0;
        @(posedge clk);
        m_out_valid = nv;
        m_redir     = nredir;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        drive(1'b0, 3'd0, 64'd0, 64'd0, 64'd0, 1'b0);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int base;
        model_reset();
        drive(1'b0, 3'd0, 64'd0, 64'd0, 64'd0, 1'b0);
        bus.out_ready      = 1'b1;
        bus.redirect_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // Reset state
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_redirect_valid", 64'(bus.redirect_valid), 64'd0);
        check_eq("rst_cnt_branch", 64'(cnt_branch), 64'd0);
        rst = 1'b0;
        idle(1);

        // T1: taken COND
        drive(1'b1, 3'd1, 64'h8000_0000, 64'h10, 64'd0, 1'b1);
        cycle();
        drive(1'b0, 3'd0, 64'd0, 64'd0, 64'd0, 1'b0);
        check_eq("t1_taken", 64'(bus.out_taken), 64'd1);
        check_eq("t1_target", bus.out_target, 64'h8000_0010);
        check_eq("t1_redirect_pc", bus.redirect_pc, 64'h8000_0010);
        check_eq("t1_link", bus.out_link, 64'h8000_0004);
        cycle();
        bus.redirect_ready = 1'b1;
        cycle();
        check_eq("t1_redir_cleared", 64'(bus.redirect_valid), 64'd0);
        idle(1);

        // T2: COND_INV not taken, then taken
        drive(1'b1, 3'd2, 64'h1000, 64'h40, 64'd0, 1'b1);
        cycle();
        drive(1'b1, 3'd2, 64'h1004, 64'h40, 64'd0, 1'b0);
        cycle();
        drive(1'b0, 3'd0, 64'd0, 64'd0, 64'd0, 1'b0);
        check_eq("t2_target", bus.out_target, 64'h1044);
        idle(2);

        // T3: misaligned JALR
        drive(1'b1, 3'd4, 64'h2000, 64'h0, 64'h8000_0103, 1'b0);
        cycle();
        drive(1'b0, 3'd0, 64'd0, 64'd0, 64'd0, 1'b0);
        check_eq("t3_target", bus.out_target, 64'h8000_0102);
        check_eq("t3_exc", 64'(bus.out_exc), 64'd1);
        check_eq("t3_taken", 64'(bus.out_taken), 64'd0);
        check_eq("t3_no_redirect", 64'(bus.redirect_valid), 64'd0);
        idle(1);

        // T4: squash three wrong-path entries while fetch stalls the redirect
        bus.redirect_ready = 1'b0;
        drive(1'b1, 3'd3, 64'h3000, 64'h100, 64'd0, 1'b0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd1, 64'h3004 + 64'(4 * i), 64'h8, 64'd0, 1'b1);
            cycle();
        end
        drive(1'b0, 3'd0, 64'd0, 64'd0, 64'd0, 1'b0);
        check_eq("t4_squash", 64'(cnt_squash), 64'd3);
        bus.redirect_ready = 1'b1;
        cycle();
        check_eq("t4_back_to_run", 64'(bus.redirect_valid), 64'd0);
        idle(1);

        // T5: backpressure then 10 back-to-back
        bus.out_ready = 1'b0;
        drive(1'b1, 3'd0, 64'h4000, 64'h0, 64'd0, 1'b0);
        cycle();
        drive(1'b1, 3'd5, 64'h4004, 64'h0, 64'd0, 1'b0);
        for (int i = 0; i < 3; i++) cycle();
        check_eq("t5_stall_in_ready", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        base = n_out;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 3'd0, 64'h5000 + 64'(4 * i), 64'h0, 64'd0, 1'b0);
            cycle();
        end
        check_eq("t5_throughput", 64'(n_out - base), 64'd10);
        idle(2);

        // T6: wrapping JAL target, then more taken ops to wrap the small counter
        drive(1'b1, 3'd3, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 64'd0, 1'b0);
        cycle();
        drive(1'b0, 3'd0, 64'd0, 64'd0, 64'd0, 1'b0);
        check_eq("t6_wrap_target", bus.out_target, 64'h10);
        check_eq("t6_wrap_redirect", bus.redirect_pc, 64'h10);
        cycle();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 3'd3, 64'h6000 + 64'(16 * i), 64'h40, 64'd0, 1'b0);
            cycle();
            idle(1);
        end
        idle(1);
        check_eq("t6_small_taken_wrapped", 64'(cnt2_taken), 64'(m_cnt_taken[2:0]));

        // Reset while a redirect is pending
        bus.redirect_ready = 1'b0;
        drive(1'b1, 3'd3, 64'h7000, 64'h80, 64'd0, 1'b0);
        cycle();
        drive(1'b0, 3'd0, 64'd0, 64'd0, 64'd0, 1'b0);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_redirect_valid", 64'(bus.redirect_valid), 64'd0);
        check_eq("rst_mid_redirect_pc", bus.redirect_pc, 64'd0);
        check_eq("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_mid_out_target", bus.out_target, 64'd0);
        check_eq("rst_mid_in_ready", 64'(bus.in_ready), 64'd0);
        check_eq("rst_mid_cnt_taken", 64'(cnt_taken), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.redirect_ready = 1'b1;
        drive(1'b1, 3'd1, 64'h8000, 64'h20, 64'd0, 1'b0);
        cycle();
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
